// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I boot/run controller: controller states and
// memory channel indices.
package rv32i_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RST_HOLD,
    ST_RUN,
    ST_DONE
  } run_state_t;

  localparam int MEM_IMEM = 0;
  localparam int MEM_DMEM = 1;

endpackage

// File: rtl/rv32i_load_port.sv
// Loader write port: per-channel word-address counters, one-cycle write
// strobe register and sticky address-wrap flag.
module rv32i_load_port
  import rv32i_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 10,
  parameter int NUM_MEM = 2,
  parameter int SEL_W   = $clog2(NUM_MEM)
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               clr,
  input  logic               acc,
  input  logic [SEL_W-1:0]   sel,
  input  logic [XLEN-1:0]    data,
  output logic [NUM_MEM-1:0] mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  output logic               ovf
);

  logic [ADDR_W-1:0]  cnt_q [NUM_MEM];
  logic [ADDR_W-1:0]  cnt_d [NUM_MEM];
  logic [NUM_MEM-1:0] we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               ovf_q, ovf_d;

  always_comb begin
    cnt_d   = cnt_q;
    we_d    = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    if (clr) begin
      for (int i = 0; i < NUM_MEM; i++) cnt_d[i] = '0;
      ovf_d = 1'b0;
    end else if (acc) begin
      // A select with no matching channel is consumed without any write.
      for (int i = 0; i < NUM_MEM; i++) begin
        if (sel == SEL_W'(i)) begin
          we_d[i]  = 1'b1;
          addr_d   = cnt_q[i];
          wdata_d  = data;
          cnt_d[i] = cnt_q[i] + 1'b1;
          if (&cnt_q[i]) ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < NUM_MEM; i++) cnt_q[i] <= '0;
      we_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      we_q  <= we_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/rv32i_run_ctrl.sv
// Boot and run controller: streams an image into the core memories, then
// holds core reset, runs the core for a budget or until halt, and reports.
module rv32i_run_ctrl
  import rv32i_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 10,
  parameter int NUM_MEM    = 2,
  parameter int SEL_W      = $clog2(NUM_MEM),
  parameter int RST_CYCLES = 5,
  parameter int CNT_W      = 32
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               load_start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [SEL_W-1:0]   ld_sel,
  input  logic               ld_last,
  input  logic [XLEN-1:0]    ld_data,
  output logic               ld_ovf,
  output logic [NUM_MEM-1:0] mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic               run_start,
  input  logic [CNT_W-1:0]   run_budget,
  input  logic               halt,
  input  logic               abort,
  output logic               core_rst_n,
  output logic               en_pc,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycles
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  run_state_t       state_q, state_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             timeout_q, timeout_d;
  logic             ld_clr, ld_acc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    budget_d  = budget_q;
    cycles_d  = cycles_q;
    rc_d      = rc_q;
    timeout_d = timeout_q;
    ld_clr    = 1'b0;
    ld_acc    = 1'b0;
    if (state_q == ST_IDLE || state_q == ST_DONE) begin
      if (load_start) begin
        state_d   = ST_LOAD;
        ld_clr    = 1'b1;
        timeout_d = 1'b0;
      end else if (run_start) begin
        state_d   = ST_RST_HOLD;
        budget_d  = run_budget;
        cycles_d  = '0;
        timeout_d = 1'b0;
        rc_d      = '0;
      end
    end else if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_LOAD: begin
          ld_acc = ld_valid;
          if (ld_valid && ld_last) state_d = ST_IDLE;
        end
        ST_RST_HOLD: begin
          if (rc_q == RC_W'(RST_CYCLES - 1)) state_d = ST_RUN;
          else rc_d = rc_q + 1'b1;
        end
        ST_RUN: begin
          cycles_d = sat_inc(cycles_q);
          // Halt takes precedence over budget expiry in the same cycle.
          if (halt) begin
            state_d = ST_DONE;
          end else if (budget_q != '0 && cycles_d == budget_q) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cycles_q  <= '0;
      rc_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      rc_q      <= rc_d;
      timeout_q <= timeout_d;
    end
  end

  always_ff @(posedge CLK) begin
    budget_q <= budget_d;
  end

  rv32i_load_port #(
    .XLEN    (XLEN),
    .ADDR_W  (ADDR_W),
    .NUM_MEM (NUM_MEM),
    .SEL_W   (SEL_W)
  ) u_load_port (
    .CLK       (CLK),
    .rst       (rst),
    .clr       (ld_clr),
    .acc       (ld_acc),
    .sel       (ld_sel),
    .data      (ld_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .ovf       (ld_ovf)
  );

  // Core stays out of reset in DONE so its state remains inspectable.
  assign ld_ready   = (state_q == ST_LOAD);
  assign core_rst_n = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign en_pc      = (state_q == ST_RUN);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RST_HOLD) || (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign timeout    = timeout_q;
  assign cycles     = cycles_q;

endmodule

// File: doc/rv32i_run_ctrl.md
Name: rv32i_run_ctrl

Overview:
- Synthesizable boot and run controller for the RV32I core.
- Streams image words into NUM_MEM memory write ports (channel 0 = IMEM, 1 = DMEM by convention).
- Then sequences core reset, gates EN_PC for a cycle budget or until the core signals halt, and reports status.
- Sits between a host/loader interface and the RV32I top; turns fixed-length, file-preloaded runs into a parametrised, repeatable hardware sequence.

Parameters:
- XLEN, 32, data word width.
- ADDR_W, 10, word-address width per memory.
- NUM_MEM, 2, number of target memories; must be >= 2.
- SEL_W, $clog2(NUM_MEM), channel select width.
- RST_CYCLES, 5, cycles core_rst_n is held low before run; must be >= 1.
- CNT_W, 32, cycle counter and budget width.

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  pulse; begins a load session.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  load word accepted when ld_valid & ld_ready.
- ld_sel  in  SEL_W  target memory for this word.
- ld_last  in  1  final word of the session.
- ld_data  in  XLEN  load word.
- ld_ovf  out  1  sticky; some channel address wrapped.
- mem_we  out  NUM_MEM  one-hot write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  XLEN  write data.
- run_start  in  1  pulse; begins a run.
- run_budget  in  CNT_W  cycle budget; 0 = unlimited.
- halt  in  1  core halt indication.
- abort  in  1  abandon current activity.
- core_rst_n  out  1  core reset, active low.
- en_pc  out  1  core PC enable.
- busy  out  1  state is not IDLE or DONE.
- done  out  1  run finished.
- timeout  out  1  run ended on budget.
- cycles  out  CNT_W  cycles with en_pc high in the current/last run.

Behaviour:
- States: IDLE, LOAD, RST_HOLD, RUN, DONE.
- Reset: state IDLE; core_rst_n=0; en_pc=0; mem_we=0; ld_ready=0; ld_ovf=0; busy=0; done=0; timeout=0; cycles=0; all channel address counters 0. rst wins over every other input.
- IDLE/DONE + load_start → LOAD:
  - clear all NUM_MEM address counters and ld_ovf; core_rst_n=0; done=0; timeout=0.
- LOAD:
  - ld_ready=1.
  - Each handshake: next cycle mem_we[ld_sel]=1 for one cycle, mem_addr=counter[ld_sel], mem_wdata=ld_data; counter[ld_sel] increments (1-cycle write latency; one write per cycle sustained).
  - Per-channel counters are independent; interleaved selects are legal.
  - Counter wrap from 2^ADDR_W-1 to 0 sets ld_ovf; the write still occurs.
  - ld_sel >= NUM_MEM: word consumed, no strobe, no counter change.
  - Handshake with ld_last → IDLE; ld_ready=0 from the next cycle.
- IDLE/DONE + run_start → RST_HOLD:
  - latch run_budget; cycles=0; done=0; timeout=0.
  - If load_start and run_start arrive together, load_start wins.
  - run_start during LOAD, RST_HOLD or RUN is ignored.
- RST_HOLD: core_rst_n=0 for exactly RST_CYCLES cycles, then → RUN.
- RUN:
  - core_rst_n=1; en_pc=1; cycles increments each RUN cycle, saturating at all-ones.
  - halt sampled high → DONE with timeout=0; en_pc=0 from the next cycle.
  - Budget B != 0: en_pc is high for exactly B cycles, then → DONE with timeout=1.
  - halt on the final budget cycle: halt wins, timeout=0.
- DONE: done=1; en_pc=0; core_rst_n stays 1 so core state and memories remain inspectable; cycles holds.
- abort in LOAD/RST_HOLD/RUN → IDLE next cycle: en_pc=0, core_rst_n=0, mem_we=0, done=0; cycles and ld_ovf hold. abort is ignored in IDLE/DONE.
- busy=1 exactly in LOAD, RST_HOLD, RUN.

Decomposition:
- Shared package rv32i_pkg: state enum run_state_t; constants MEM_IMEM=0, MEM_DMEM=1.
- One sub-module: rv32i_load_port, containing the per-channel address counters, write-strobe register and overflow flag.
- The FSM and run counter live in the top.

Test Plan:
- Reset then idle: rst high 3 cycles → all outputs at reset values; core_rst_n=0, en_pc=0.
- Load: load_start; 4 words to sel 0 (0x00500093…), 2 words to sel 1, last on the 6th → mem_we[0] pulses at addr 0..3, mem_we[1] at addr 0..1, each one cycle after its handshake; ld_ready drops after last.
- Budget run: run_start, run_budget=500, halt=0 → core_rst_n low exactly 5 cycles; en_pc high exactly 500 cycles; done=1, timeout=1, cycles=500.
- Halt run: budget 0; halt pulsed on the 37th RUN cycle → done=1, timeout=0, cycles=37. Repeat with budget=37 → timeout=0 (halt wins).
- Wrap: ADDR_W=2; 5 words to sel 0 → addresses 0,1,2,3,0; ld_ovf=1.
- Abort mid-RUN at cycle 10 → next cycle IDLE, en_pc=0, core_rst_n=0, done=0; a subsequent run_start is accepted.
